// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// The master side raises stall/flush requests; the slave side returns per-stage controls.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int PC_W   = 32
);
  logic [STAGES-1:0] stallreq;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] flush;
  logic              new_pc_valid;
  logic [PC_W-1:0]   new_pc;
  logic              busy;
  logic              stall_timeout;
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_count;

  modport master (
    output stallreq, flush_req, flush_pc,
    input  stall, bubble, flush, new_pc_valid, new_pc, busy,
           stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq, flush_req, flush_pc,
    output stall, bubble, flush, new_pc_valid, new_pc, busy,
           stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, flush/redirect sequencer and stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles / flush_count perf counters.
module pipe_ctrl #(
  parameter int STAGES     = 6,
  parameter int PC_W       = 32,
  parameter int REFILL_CYC = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_t;

  localparam logic [3:0] REFILL_LAST = (REFILL_CYC > 0) ? 4'(REFILL_CYC - 1) : 4'd0;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic [PC_W-1:0]   new_pc_q, new_pc_d;
  logic [3:0]        refill_q, refill_d;

  logic [STAGES-1:0] stall_arb, bubble_arb;
  logic [STAGES-1:0] stall_o, bubble_o, flush_o;
  logic              any_req;
  logic              unused_stallreq0;

  assign unused_stallreq0 = bus.stallreq[0];

  // A request at stage h holds every stage up to h and injects a NOP just behind it.
  always_comb begin
    stall_arb  = '0;
    bubble_arb = '0;
    any_req    = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k >= 1) any_req = any_req | bus.stallreq[k];
      stall_arb[k] = any_req;
    end
    for (int k = 1; k < STAGES; k++) begin
      bubble_arb[k] = stall_arb[k-1] & ~stall_arb[k];
    end
  end

  always_comb begin
    stall_o  = stall_arb;
    bubble_o = bubble_arb;
    flush_o  = '0;
    if (state_q == FLUSH) begin
      stall_o  = '0;
      bubble_o = '0;
      flush_o  = {{(STAGES-1){1'b1}}, 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pend_pc_d = pend_pc_q;
    new_pc_d  = new_pc_q;
    refill_d  = refill_q;
    case (state_q)
      RUN: begin
        if (pending_q) begin
          // A fresh request arriving while the deferred one launches is kept for the next window.
          state_d   = FLUSH;
          new_pc_d  = pend_pc_q;
          pending_d = bus.flush_req;
          if (bus.flush_req) pend_pc_d = bus.flush_pc;
        end else if (bus.flush_req) begin
          state_d  = FLUSH;
          new_pc_d = bus.flush_pc;
        end
      end
      FLUSH: begin
        if (bus.flush_req) begin
          pending_d = 1'b1;
          pend_pc_d = bus.flush_pc;
        end
        if (REFILL_CYC > 0) begin
          state_d  = REFILL;
          refill_d = REFILL_LAST;
        end else begin
          state_d = RUN;
        end
      end
      REFILL: begin
        if (bus.flush_req) begin
          pending_d = 1'b1;
          pend_pc_d = bus.flush_pc;
        end
        if (refill_q == 4'd0) state_d = RUN;
        else                  refill_d = refill_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
      pend_pc_q <= '0;
      new_pc_q  <= '0;
      refill_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pend_pc_q <= pend_pc_d;
      new_pc_q  <= new_pc_d;
      refill_q  <= refill_d;
    end
  end

  assign bus.stall        = stall_o;
  assign bus.bubble       = bubble_o;
  assign bus.flush        = flush_o;
  assign bus.new_pc_valid = (state_q == FLUSH);
  assign bus.new_pc       = new_pc_q;
  assign bus.busy         = (state_q != RUN);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WDW = $clog2(TIMEOUT + 1);
      logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
      logic           timeout_q, timeout_d;

      // Counts consecutive PC-hold cycles, parking at TIMEOUT; the flag is sticky until reset.
      always_comb begin
        wd_cnt_d = '0;
        if (stall_o[0]) begin
          wd_cnt_d = (wd_cnt_q == WDW'(TIMEOUT)) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_cnt_d == WDW'(TIMEOUT));
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wd_cnt_q  <= '0;
          timeout_q <= 1'b0;
        end else begin
          wd_cnt_q  <= wd_cnt_d;
          timeout_q <= timeout_d;
        end
      end

      assign bus.stall_timeout = timeout_q;
    end else begin : g_no_wd
      assign bus.stall_timeout = 1'b0;
    end
  endgenerate

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_o[0]};
    flush_count_d  = flush_count_q + {31'd0, (state_d == FLUSH)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven arbitration vectors plus
// hand sequences for flush, deferred flush, watchdog and reset abort.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_ctrl_if #(.STAGES(6), .PC_W(32)) bus ();

  pipe_ctrl #(
    .STAGES(6), .PC_W(32), .REFILL_CYC(2), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  typedef struct {
    logic [5:0] sr;
    logic [5:0] exp_stall;
    logic [5:0] exp_bubble;
  } vec_t;

  vec_t vecs [10];

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // One call per cycle: inputs change 1ns after the edge, outputs are sampled 1ns later.
  task automatic apply_stimulus(input logic [5:0] sr, input logic fr, input logic [31:0] pc);
    @(posedge clk);
    #1;
    bus.stallreq  = sr;
    bus.flush_req = fr;
    bus.flush_pc  = pc;
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(6'd0, 1'b0, 32'd0);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_stall"},  32'(bus.stall), 32'd0);
    check_output({tag, "_bubble"}, 32'(bus.bubble), 32'd0);
    check_output({tag, "_flush"},  32'(bus.flush), 32'd0);
    check_output({tag, "_npv"},    32'(bus.new_pc_valid), 32'd0);
    check_output({tag, "_new_pc"}, bus.new_pc, 32'd0);
    check_output({tag, "_busy"},   32'(bus.busy), 32'd0);
    check_output({tag, "_tmo"},    32'(bus.stall_timeout), 32'd0);
    check_output({tag, "_scyc"},   bus.stall_cycles, 32'd0);
    check_output({tag, "_fcnt"},   bus.flush_count, 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.stallreq  = '0;
    bus.flush_req = 1'b0;
    bus.flush_pc  = '0;

    vecs[0] = '{6'b000100, 6'b000111, 6'b001000};
    vecs[1] = '{6'b000100, 6'b000111, 6'b001000};
    vecs[2] = '{6'b000100, 6'b000111, 6'b001000};
    vecs[3] = '{6'b010100, 6'b011111, 6'b100000};
    vecs[4] = '{6'b100000, 6'b111111, 6'b000000};
    vecs[5] = '{6'b000000, 6'b000000, 6'b000000};
    vecs[6] = '{6'b000001, 6'b000000, 6'b000000};
    vecs[7] = '{6'b000010, 6'b000011, 6'b000100};
    vecs[8] = '{6'b001000, 6'b001111, 6'b010000};
    vecs[9] = '{6'b000000, 6'b000000, 6'b000000};

    // Reset state
    apply_stimulus(6'd0, 1'b0, 32'd0);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_all_zero("reset");
    rst = 1'b0;

    // Combinational arbitration in RUN
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].sr, 1'b0, 32'd0);
      check_output($sformatf("vec%0d_stall", i),  32'(bus.stall), 32'(vecs[i].exp_stall));
      check_output($sformatf("vec%0d_bubble", i), 32'(bus.bubble), 32'(vecs[i].exp_bubble));
      check_output($sformatf("vec%0d_flush", i),  32'(bus.flush), 32'd0);
      check_output($sformatf("vec%0d_busy", i),   32'(bus.busy), 32'd0);
      check_output($sformatf("vec%0d_tmo", i),    32'(bus.stall_timeout), 32'd0);
    end

    // Single flush with REFILL_CYC=2
    do_reset();
    apply_stimulus(6'd0, 1'b1, 32'hBFC00380);
    check_output("fl_n_busy", 32'(bus.busy), 32'd0);
    apply_stimulus(6'b000100, 1'b0, 32'd0);
    check_output("fl_n1_flush",  32'(bus.flush), 32'b111110);
    check_output("fl_n1_npv",    32'(bus.new_pc_valid), 32'd1);
    check_output("fl_n1_new_pc", bus.new_pc, 32'hBFC00380);
    check_output("fl_n1_stall",  32'(bus.stall), 32'd0);
    check_output("fl_n1_bubble", 32'(bus.bubble), 32'd0);
    check_output("fl_n1_busy",   32'(bus.busy), 32'd1);
    apply_stimulus(6'b000100, 1'b0, 32'd0);
    check_output("fl_n2_flush",  32'(bus.flush), 32'd0);
    check_output("fl_n2_npv",    32'(bus.new_pc_valid), 32'd0);
    check_output("fl_n2_stall",  32'(bus.stall), 32'b000111);
    check_output("fl_n2_bubble", 32'(bus.bubble), 32'b001000);
    check_output("fl_n2_busy",   32'(bus.busy), 32'd1);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("fl_n3_busy",   32'(bus.busy), 32'd1);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("fl_n4_busy",   32'(bus.busy), 32'd0);
    check_output("fl_n4_npv",    32'(bus.new_pc_valid), 32'd0);
    check_output("fl_n4_new_pc", bus.new_pc, 32'hBFC00380);
    check_output("fl_n4_fcnt",   bus.flush_count, PERF ? 32'd1 : 32'd0);

    // Flush request during REFILL is deferred until RUN
    do_reset();
    apply_stimulus(6'd0, 1'b1, 32'hBFC00380);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("pd_n1_npv", 32'(bus.new_pc_valid), 32'd1);
    apply_stimulus(6'd0, 1'b1, 32'h80000100);
    check_output("pd_n2_npv",  32'(bus.new_pc_valid), 32'd0);
    check_output("pd_n2_busy", 32'(bus.busy), 32'd1);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("pd_n3_busy", 32'(bus.busy), 32'd1);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("pd_n4_busy",  32'(bus.busy), 32'd0);
    check_output("pd_n4_npv",   32'(bus.new_pc_valid), 32'd0);
    check_output("pd_n4_flush", 32'(bus.flush), 32'd0);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("pd_n5_flush",  32'(bus.flush), 32'b111110);
    check_output("pd_n5_npv",    32'(bus.new_pc_valid), 32'd1);
    check_output("pd_n5_new_pc", bus.new_pc, 32'h80000100);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("pd_n6_busy", 32'(bus.busy), 32'd1);
    check_output("pd_n6_npv",  32'(bus.new_pc_valid), 32'd0);
    check_output("pd_n6_fcnt", bus.flush_count, PERF ? 32'd2 : 32'd0);

    // Watchdog with TIMEOUT=8: flag visible from the cycle after the 8th stalled cycle
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(6'b000100, 1'b0, 32'd0);
      check_output($sformatf("wd_c%0d_tmo", i), 32'(bus.stall_timeout), (i >= 9) ? 32'd1 : 32'd0);
    end
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("wd_drop_tmo",  32'(bus.stall_timeout), 32'd1);
    check_output("wd_drop_scyc", bus.stall_cycles, PERF ? 32'd10 : 32'd0);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("wd_hold_tmo",  32'(bus.stall_timeout), 32'd1);

    // Reset during REFILL with a pending flush aborts everything
    do_reset();
    apply_stimulus(6'd0, 1'b1, 32'hBFC00380);
    apply_stimulus(6'd0, 1'b1, 32'h80000200);
    check_output("ra_flush_npv", 32'(bus.new_pc_valid), 32'd1);
    apply_stimulus(6'd0, 1'b0, 32'd0);
    check_output("ra_refill_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    apply_stimulus(6'd0, 1'b0, 32'd0);
    rst = 1'b0;
    check_all_zero("ra_after");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(6'd0, 1'b0, 32'd0);
      check_output($sformatf("ra_c%0d_npv", i),   32'(bus.new_pc_valid), 32'd0);
      check_output($sformatf("ra_c%0d_flush", i), 32'(bus.flush), 32'd0);
      check_output($sformatf("ra_c%0d_busy", i),  32'(bus.busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the in-order MIPS core. It is the successor to the fixed 6-bit stall controller. It arbitrates per-stage stall requests into a STAGES-wide stall bus plus explicit bubble and flush vectors. It also adds a registered flush/redirect sequencer with a minimum re-flush spacing and a stall watchdog. It sits beside the pipeline stages in the core top level and drives every stage register's hold, bubble and flush inputs.

Parameters:
STAGES, 6, width of stall/bubble/flush buses; bit 0 = PC, bit k = stage-k pipeline register (1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
PC_W, 32, width of redirect PC
REFILL_CYC, 2, cycles after a flush during which new flush requests are deferred; range 0..15
TIMEOUT, 1024, consecutive stalled cycles before stall_timeout sets; 0 disables the watchdog

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous, active-high
stallreq  in  STAGES  bit k = stage k requests hold; bit 0 ignored
flush_req  in  1  exception/redirect request, single-cycle pulse or level
flush_pc  in  PC_W  redirect target, valid with flush_req
stall  out  STAGES  bit k = 1 means hold stage-k register
bubble  out  STAGES  bit k = 1 means load a NOP into stage-k register
flush  out  STAGES  bit k = 1 means clear stage-k register
new_pc_valid  out  1  PC must load new_pc this cycle
new_pc  out  PC_W  redirect target
busy  out  1  sequencer not in RUN
stall_timeout  out  1  sticky watchdog flag
stall_cycles  out  32  perf counter (see Optional Feature)
flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge) sets the FSM to RUN and clears pending, refill counter, watchdog counter, stall_timeout, both perf counters and the new_pc register. All outputs read 0 in the cycle after reset.
- Stall arbitration is combinational. Let h be the highest k≥1 with stallreq[k]=1. Then stall[h:0]=1 and stall[STAGES-1:h+1]=0. bubble[h+1]=1 when h+1<STAGES. With no request, stall and bubble are 0. Example for STAGES=6: an ID request gives stall=6'b000111 and bubble=6'b001000.
- FSM states are RUN, FLUSH and REFILL.
- RUN to FLUSH: taken on flush_req=1 or pending=1. new_pc is latched from flush_pc, or from the pending target when pending is set.
- FLUSH lasts exactly 1 cycle:
  - flush[STAGES-1:1]=all ones and flush[0]=0.
  - new_pc_valid=1 and new_pc holds the latched target.
  - stall=0 and bubble=0; flush overrides all stall requests.
  - Next state is REFILL if REFILL_CYC>0, else RUN.
- REFILL counts REFILL_CYC cycles. Stall arbitration runs normally in this state. Next state is RUN when the count expires.
- Latency: flush_req sampled at edge n produces flush and new_pc_valid during cycle n+1.
- flush_req during FLUSH or REFILL sets pending and stores flush_pc. A later request in the same window overwrites the stored target (last wins). pending is serviced on the first RUN cycle, so FLUSH follows in the next cycle, and then pending clears.
- busy=1 in FLUSH and REFILL.
- Watchdog:
  - The counter increments on each cycle with stall[0]=1 and resets to 0 on any cycle with stall[0]=0.
  - It saturates at TIMEOUT.
  - stall_timeout sets when the counter reaches TIMEOUT and stays set until rst.
  - No watchdog logic exists when TIMEOUT=0.
- Reset mid-FLUSH or mid-REFILL aborts the sequence and drops pending; no new_pc_valid is issued afterwards.

Optional Feature:
PIPE_CTRL_PERF_EN.
- Defined: stall_cycles increments on every cycle with stall[0]=1, and flush_count increments on every entry to FLUSH. Both wrap at 2^32 and clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- STAGES=6, stallreq=6'b000100 held 3 cycles -> stall=6'b000111 and bubble=6'b001000 each cycle; stall_timeout=0.
- stallreq=6'b010100 -> stall=6'b011111 and bubble=6'b100000; then stallreq=6'b100000 -> stall=6'b111111 and bubble=0.
- flush_req pulse with flush_pc=32'hBFC00380 at edge n, REFILL_CYC=2 -> cycle n+1: flush=6'b111110, new_pc_valid=1, new_pc=32'hBFC00380; busy=1 for cycles n+1..n+3; RUN at n+4.
- Flush at edge n, then flush_req with flush_pc=32'h80000100 at edge n+2 (during REFILL) -> second FLUSH in cycle n+5 with new_pc=32'h80000100; flush_count=2 when PIPE_CTRL_PERF_EN is defined.
- TIMEOUT=8, stallreq[2] held 10 cycles -> stall_timeout rises after the 8th stalled cycle and stays 1 after stallreq drops; stall_cycles=10 with PIPE_CTRL_PERF_EN.
- rst asserted in the REFILL cycle while pending=1 -> all outputs 0 the next cycle; no FLUSH occurs afterwards without a new flush_req.
